// File: rtl/gray_seq_pkg.sv
// Shared types and the binary-to-Gray helper for the Gray sequencer.
package gray_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    CMD_START,
    CMD_STOP,
    CMD_STEP,
    CMD_LOAD
  } cmd_op_e;

  localparam int GRAY_MAX_W = 32;

  // Callers zero-extend into GRAY_MAX_W and cast the result back to their width.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_seq_ctrl.sv
// Command-driven binary counter with Gray output; commands take effect at the accept edge,
// wrap/cmd_err are registered pulses, cmd_ready is high in every state once out of reset.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RST_LIMIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             cmd_oneshot,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             cmd_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             oneshot_q, oneshot_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             ready_q;

  logic             accept;
  cmd_op_e          op;
  logic             at_limit;
  logic [WIDTH-1:0] step_bin;

  assign accept   = cmd_valid & ready_q;
  assign op       = cmd_op_e'(cmd_op);
  // Wrap is relative to the programmed limit, so natural overflow past all-ones is silent.
  assign at_limit = (bin_q == limit_q);
  assign step_bin = at_limit ? '0 : bin_q + WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    limit_d   = limit_q;
    oneshot_d = oneshot_q;
    wrap_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      RUN: begin
        if (accept && op == CMD_STOP) begin
          state_d = IDLE;
        end else begin
          err_d = accept;
          if (oneshot_q && at_limit) begin
            state_d = DONE;
          end else begin
            bin_d  = step_bin;
            wrap_d = at_limit;
          end
        end
      end
      default: begin
        // IDLE and DONE share command handling; DONE only differs in holding until a command.
        if (accept) begin
          state_d = IDLE;
          case (op)
            CMD_START: begin
              limit_d   = cmd_arg;
              oneshot_d = cmd_oneshot;
              state_d   = RUN;
            end
            CMD_STEP: begin
              bin_d  = step_bin;
              wrap_d = at_limit;
            end
            CMD_LOAD: bin_d = cmd_arg;
            CMD_STOP: ;
            default:  ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      limit_q   <= RST_LIMIT;
      oneshot_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      limit_q   <= limit_d;
      oneshot_q <= oneshot_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      ready_q   <= 1'b1;
    end
  end

  assign cmd_ready = ready_q;
  assign bin_o     = bin_q;
  assign gray_o    = WIDTH'(bin2gray(GRAY_MAX_W'(bin_q)));
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign wrap      = wrap_q;
  assign cmd_err   = err_q;

endmodule
